// File: rtl/clk_mon.sv
// ---------------------------------------------------------------------------
// clk_mon
//   Monitors a slow clock (mon_clk) that is asynchronous to clk_in. mon_clk is
//   synchronized into the clk_in domain, its edges are turned into one-cycle
//   ticks, and the rise-to-rise (period) and rise-to-fall (high_time) intervals
//   are measured in clk_in cycles. If no rising edge arrives within TIMEOUT
//   cycles the monitor flags a sticky clk_lost and drops back to IDLE.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on mon_clk (2 or 3)
//   CNT_W        width of the interval counter, period and high_time
//   TIMEOUT      cycles without a rise before loss (2 .. 2^CNT_W-1)
//
// Ports
//   clk_in      in   sole clock, rising edge
//   reset       in   asynchronous, active-high
//   mon_clk     in   monitored clock, asynchronous to clk_in
//   rise_tick   out  one-cycle pulse per detected mon_clk rise
//   fall_tick   out  one-cycle pulse per detected mon_clk fall
//   period      out  last rise-to-rise interval (clk_in cycles)
//   high_time   out  last rise-to-fall interval (clk_in cycles)
//   meas_valid  out  period holds a valid measurement
//   clk_lost    out  sticky loss flag, cleared by the next rise
// ---------------------------------------------------------------------------
module clk_mon #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             mon_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             clk_lost
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // no rise since reset or loss
        ARMED  = 2'd1,  // one rise seen, counting the first period
        LOCKED = 2'd2   // at least one full period measured
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t                  state, state_nx;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    prev_q;
    logic                    sync_s;
    logic                    rise, fall;
    logic                    timeout;

    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [CNT_W-1:0]        period_nx, high_nx;
    logic                    meas_nx, lost_nx;

    // ---------------- synchronizer and edge detect ----------------
    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;
    assign fall   = ~sync_s & prev_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            prev_q    <= sync_s;
            rise_tick <= rise;
            fall_tick <= fall;
        end
    end

    // ---------------- state and measurement registers ----------------
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            clk_lost   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            period     <= period_nx;
            high_time  <= high_nx;
            meas_valid <= meas_nx;
            clk_lost   <= lost_nx;
        end
    end

    // A rise always wins over a coinciding timeout, so a clock whose period
    // equals TIMEOUT exactly is still considered alive.
    assign timeout = (state != IDLE) && !rise && (cnt == TIMEOUT_C);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        period_nx = period;
        high_nx   = high_time;
        meas_nx   = meas_valid;
        lost_nx   = clk_lost;

        // Counter restarts at 1 on each rise so that rises N cycles apart
        // read back as N on the next rise.
        if (rise)
            cnt_nx = CNT_ONE;
        else if (state != IDLE && cnt != CNT_MAX)
            cnt_nx = cnt + CNT_ONE;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = ARMED;
                    lost_nx  = 1'b0;
                end
            end
            ARMED, LOCKED: begin
                if (rise) begin
                    state_nx  = LOCKED;
                    period_nx = cnt;
                    meas_nx   = 1'b1;
                end else if (timeout) begin
                    state_nx = IDLE;
                    lost_nx  = 1'b1;
                    meas_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A fall on the timeout cycle is ignored so the last good high_time
        // survives the loss.
        if (fall && state != IDLE && !timeout)
            high_nx = cnt;
    end

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer flop count on mon_clk; legal values are 2 and 3.
REQ-002 Parameter CNT_W, default 8, width of the cycle counter, period and high_time.
REQ-003 Parameter TIMEOUT, default 64, clk_in cycles without a rising edge before loss is declared; legal range is 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-004 clk_in  input  1  sole clock; all flops are rising-edge clk_in.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mon_clk  input  1  monitored slow clock (e.g. divided clock), asynchronous to clk_in.
REQ-007 rise_tick  output  1  one-cycle pulse per detected mon_clk rising edge.
REQ-008 fall_tick  output  1  one-cycle pulse per detected mon_clk falling edge.
REQ-009 period  output  CNT_W  last measured rise-to-rise interval, in clk_in cycles.
REQ-010 high_time  output  CNT_W  last measured rise-to-fall interval, in clk_in cycles.
REQ-011 meas_valid  output  1  level; period is a valid measurement.
REQ-012 clk_lost  output  1  level, sticky; mon_clk loss detected.

Function
REQ-013 mon_clk SHALL pass through a SYNC_STAGES-deep flop chain; a further flop (prev) SHALL hold the previous synchronized value.
REQ-014 Internal rise r = sync & ~prev and fall f = ~sync & prev; rise_tick/fall_tick SHALL be registered copies of r/f, asserted exactly one cycle per edge.
REQ-015 A mon_clk transition meeting setup before clk_in edge k SHALL produce its tick high in the cycle following edge k+SYNC_STAGES.
REQ-016 The FSM SHALL have states IDLE (no rise since reset/loss), ARMED (one rise seen) and LOCKED (at least one full period measured).
REQ-017 Counter cnt SHALL load 1 on any edge where r=1, and otherwise increment by 1 when the state is not IDLE, saturating at 2^CNT_W-1.
REQ-018 IDLE + r: the FSM SHALL go to ARMED, set clk_lost <= 0, and leave period unchanged.
REQ-019 ARMED + r: the FSM SHALL go to LOCKED, set period <= cnt, and set meas_valid <= 1.
REQ-020 LOCKED + r: the FSM SHALL stay in LOCKED and set period <= cnt, so that rises N cycles apart yield period = N in the same cycle as rise_tick.
REQ-021 f while not IDLE SHALL set high_time <= cnt; f while IDLE SHALL only pulse fall_tick.
REQ-022 Not IDLE, r=0 and cnt == TIMEOUT: the FSM SHALL go to IDLE, set clk_lost <= 1 and set meas_valid <= 0; period and high_time SHALL hold their values.
REQ-023 When r and the timeout condition coincide, r SHALL win and no loss SHALL be flagged.
REQ-024 A mon_clk stuck at 1 or stuck at 0 SHALL both trigger loss via REQ-022.

Reset
REQ-025 reset SHALL asynchronously clear the synchronizer, prev, cnt, period, high_time, rise_tick, fall_tick, meas_valid and clk_lost to 0, and force the state to IDLE.
REQ-026 reset asserted mid-measurement SHALL discard all partial counts; after release, the first rise SHALL only arm the block (no period update).
REQ-027 Outputs SHALL remain 0 for at least SYNC_STAGES+1 cycles after reset release, regardless of mon_clk.

Verification
REQ-028 mon_clk = clk_in/4 (2 high, 2 low), aligned after reset -> second rise_tick: period=4, meas_valid=1; each fall: high_time=2.
REQ-029 mon_clk = clk_in/3 from an odd divider -> period=3 on every rise after lock; exactly one rise_tick and one fall_tick per mon_clk cycle.
REQ-030 Locked on /4, then mon_clk held at 0 -> clk_lost=1 and meas_valid=0, TIMEOUT cycles after the last rise_tick cycle; period still 4.
REQ-031 After loss, mon_clk restarted at /6 -> first rise: clk_lost=0, state ARMED; second rise: period=6, meas_valid=1.
REQ-032 TIMEOUT=8 with rises 8 cycles apart -> no clk_lost (rise wins the tie); rises 9 apart -> clk_lost=1, then the next rise re-arms the block.
REQ-033 reset pulsed mid-period while locked -> all outputs 0 immediately (asynchronously); the next rise arms, and the following rise gives the correct period.
